pconv_sched: RTL and testbench

Pass scheduler for the pointwise (1x1) convolution datapath. It splits a layer of `OC_TOTAL` output channels into passes of `OC_PAR` channels, which is the width of the parallel datapath. For each pass it fetches that group's weights, bias and shift through a request/acknowledge handshake, then streams all `PIX` input pixels from the feature-map RAM into the datapath. It collects exactly `PIX` results per pass and writes them to the output RAM at sequential addresses. It sits between the layer-level controller (`start`/`done`) and the pointwise datapath, its parameter loader, and the feature-map and output RAMs.

---
 rtl/pconv_sched_if.sv | 32 +++
 rtl/pconv_sched.sv | 187 ++++++++++++++++++
 tb/tb_pconv_sched.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pconv_sched_if.sv
// Handshake and bus bundle between the pointwise pass scheduler and its neighbours:
// layer controller, parameter loader, datapath, feature-map RAM and output RAM.
interface pconv_sched_if #(
    parameter int ADDR_W = 12,
    parameter int GRP_W  = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic              param_req;
    logic [GRP_W-1:0]  param_grp;
    logic              param_ack;
    logic              fm_rd_en;
    logic [ADDR_W-1:0] fm_rd_addr;
    logic              dp_ce;
    logic              dp_input_vld;
    logic              dp_dout_vld;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_wr_addr;

    modport master (
        input  start, param_ack, dp_dout_vld,
        output busy, done, param_req, param_grp, fm_rd_en, fm_rd_addr,
               dp_ce, dp_input_vld, out_wr_en, out_wr_addr
    );

    modport slave (
        output start, param_ack, dp_dout_vld,
        input  busy, done, param_req, param_grp, fm_rd_en, fm_rd_addr,
               dp_ce, dp_input_vld, out_wr_en, out_wr_addr
    );
endinterface

// File: rtl/pconv_sched.sv
// Pass scheduler for the 1x1 convolution datapath: per pass it loads one parameter
// group, streams every input pixel, and collects exactly PIX results into the output RAM.
module pconv_sched #(
    parameter int INPUT_SIZE = 6,
    parameter int OC_TOTAL   = 64,
    parameter int OC_PAR     = 32,
    parameter int ADDR_W     = 12,
    parameter int GRP_W      = 4
) (
    input  logic          clk,
    input  logic          rst,
    pconv_sched_if.master bus
);
    localparam int PIX    = INPUT_SIZE * INPUT_SIZE;
    localparam int PASSES = OC_TOTAL / OC_PAR;
    localparam int CNT_W  = $clog2(PIX + 1);

    localparam logic [CNT_W-1:0]  PIX_C     = CNT_W'(PIX);
    localparam logic [CNT_W-1:0]  PIX_M1    = CNT_W'(PIX - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [GRP_W-1:0]  LAST_PASS = GRP_W'(PASSES - 1);
    localparam logic [GRP_W-1:0]  GRP_ONE   = GRP_W'(1);
    localparam logic [ADDR_W-1:0] PIX_A     = ADDR_W'(PIX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_GAP    = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t            state_q,        state_d;
    logic [GRP_W-1:0]  pass_q,         pass_d;
    logic [CNT_W-1:0]  rd_cnt_q,       rd_cnt_d;
    logic [CNT_W-1:0]  res_cnt_q,      res_cnt_d;
    logic              busy_q,         busy_d;
    logic              done_q,         done_d;
    logic              param_req_q,    param_req_d;
    logic [GRP_W-1:0]  param_grp_q,    param_grp_d;
    logic              fm_rd_en_q,     fm_rd_en_d;
    logic [ADDR_W-1:0] fm_rd_addr_q,   fm_rd_addr_d;
    logic              dp_ce_q,        dp_ce_d;
    logic              dp_input_vld_q, dp_input_vld_d;

    logic              wr_en_s;
    logic [CNT_W-1:0]  res_inc_s;

    // Results are accepted only while the datapath is live and the pass quota is not yet met.
    always_comb begin
        wr_en_s   = bus.dp_dout_vld
                    && ((state_q == S_STREAM) || (state_q == S_DRAIN))
                    && (res_cnt_q < PIX_C);
        res_inc_s = wr_en_s ? (res_cnt_q + CNT_ONE) : res_cnt_q;
    end

    // Next-state and next-output logic for the pass sequencer.
    always_comb begin
        state_d        = state_q;
        pass_d         = pass_q;
        rd_cnt_d       = rd_cnt_q;
        res_cnt_d      = res_cnt_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        param_req_d    = param_req_q;
        param_grp_d    = param_grp_q;
        fm_rd_en_d     = fm_rd_en_q;
        fm_rd_addr_d   = fm_rd_addr_q;
        dp_ce_d        = dp_ce_q;
        dp_input_vld_d = fm_rd_en_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_LOAD;
                    pass_d      = '0;
                    busy_d      = 1'b1;
                    param_req_d = 1'b1;
                    param_grp_d = '0;
                end else begin
                    dp_ce_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (bus.param_ack) begin
                    state_d      = S_STREAM;
                    param_req_d  = 1'b0;
                    rd_cnt_d     = '0;
                    res_cnt_d    = '0;
                    fm_rd_en_d   = 1'b1;
                    fm_rd_addr_d = '0;
                    dp_ce_d      = 1'b1;
                end else begin
                    dp_ce_d = 1'b0;
                end
            end
            S_STREAM: begin
                rd_cnt_d  = rd_cnt_q + CNT_ONE;
                res_cnt_d = res_inc_s;
                if (rd_cnt_q == PIX_M1) begin
                    state_d      = S_DRAIN;
                    fm_rd_en_d   = 1'b0;
                    fm_rd_addr_d = '0;
                end else begin
                    fm_rd_en_d   = 1'b1;
                    fm_rd_addr_d = ADDR_W'(rd_cnt_q + CNT_ONE);
                end
            end
            S_DRAIN: begin
                res_cnt_d = res_inc_s;
                if (res_inc_s == PIX_C) begin
                    state_d = S_GAP;
                    dp_ce_d = 1'b0;
                end else begin
                    dp_ce_d = 1'b1;
                end
            end
            S_GAP: begin
                if (pass_q == LAST_PASS) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d     = S_LOAD;
                    pass_d      = pass_q + GRP_ONE;
                    param_req_d = 1'b1;
                    param_grp_d = pass_q + GRP_ONE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                param_req_d  = 1'b0;
                fm_rd_en_d   = 1'b0;
                fm_rd_addr_d = '0;
                dp_ce_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            pass_q         <= '0;
            rd_cnt_q       <= '0;
            res_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            param_req_q    <= 1'b0;
            param_grp_q    <= '0;
            fm_rd_en_q     <= 1'b0;
            fm_rd_addr_q   <= '0;
            dp_ce_q        <= 1'b0;
            dp_input_vld_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            rd_cnt_q       <= rd_cnt_d;
            res_cnt_q      <= res_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            param_req_q    <= param_req_d;
            param_grp_q    <= param_grp_d;
            fm_rd_en_q     <= fm_rd_en_d;
            fm_rd_addr_q   <= fm_rd_addr_d;
            dp_ce_q        <= dp_ce_d;
            dp_input_vld_q <= dp_input_vld_d;
        end
    end

    // The write path is deliberately combinational so a result lands in the cycle it appears.
    assign bus.out_wr_en    = wr_en_s;
    assign bus.out_wr_addr  = (ADDR_W'(pass_q) * PIX_A) + ADDR_W'(res_cnt_q);
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.param_req    = param_req_q;
    assign bus.param_grp    = param_grp_q;
    assign bus.fm_rd_en     = fm_rd_en_q;
    assign bus.fm_rd_addr   = fm_rd_addr_q;
    assign bus.dp_ce        = dp_ce_q;
    assign bus.dp_input_vld = dp_input_vld_q;
endmodule

// File: tb/tb_pconv_sched.sv
// Directed bench for pconv_sched: a cycle model predicts every output, and a write
// scoreboard queues expected output addresses as datapath results are driven.
module tb_pconv_sched;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_ACT  = 2;
    localparam int M_GAP  = 3;
    localparam int M_FIN  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, ack, vld, sel;

    pconv_sched_if #(.ADDR_W(12), .GRP_W(4)) if_a ();
    pconv_sched_if #(.ADDR_W(12), .GRP_W(4)) if_b ();

    pconv_sched #(.INPUT_SIZE(6), .OC_TOTAL(64), .OC_PAR(32), .ADDR_W(12), .GRP_W(4))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    pconv_sched #(.INPUT_SIZE(1), .OC_TOTAL(32), .OC_PAR(32), .ADDR_W(12), .GRP_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.start       = start & ~sel;
    assign if_a.param_ack   = ack & ~sel;
    assign if_a.dp_dout_vld = vld & ~sel;
    assign if_b.start       = start & sel;
    assign if_b.param_ack   = ack & sel;
    assign if_b.dp_dout_vld = vld & sel;

    logic        o_busy, o_done, o_req, o_rd_en, o_ce, o_in_vld, o_wr_en;
    logic [3:0]  o_grp;
    logic [11:0] o_rd_addr, o_wr_addr;
    assign o_busy    = sel ? if_b.busy         : if_a.busy;
    assign o_done    = sel ? if_b.done         : if_a.done;
    assign o_req     = sel ? if_b.param_req    : if_a.param_req;
    assign o_grp     = sel ? if_b.param_grp    : if_a.param_grp;
    assign o_rd_en   = sel ? if_b.fm_rd_en     : if_a.fm_rd_en;
    assign o_rd_addr = sel ? if_b.fm_rd_addr   : if_a.fm_rd_addr;
    assign o_ce      = sel ? if_b.dp_ce        : if_a.dp_ce;
    assign o_in_vld  = sel ? if_b.dp_input_vld : if_a.dp_input_vld;
    assign o_wr_en   = sel ? if_b.out_wr_en    : if_a.out_wr_en;
    assign o_wr_addr = sel ? if_b.out_wr_addr  : if_a.out_wr_addr;

    int vectors = 0;
    int miscompares = 0;

    int m_state = M_IDLE, m_pass = 0, m_rd = 0, m_res = 0, m_loadcyc = 0;
    int m_pix = 36, m_passes = 2;
    bit m_prev_rd = 1'b0;
    int ack_delay = 3, mode = 0, pending = 0;
    bit extra_start = 1'b0, extra_ack = 1'b0;
    logic [7:0] hist = 8'd0;
    int n_wr = 0, n_rd = 0, n_done = 0, n_req = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_counts();
        n_wr = 0; n_rd = 0; n_done = 0; n_req = 0; hist = 8'd0; pending = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input bit do_rst, input bit do_start);
        bit a, v, st, e_en, e_wr, e_ce, drain;
        a  = ((m_state == M_LOAD) && (m_loadcyc == ack_delay))
             || (extra_ack && (m_state == M_ACT) && (m_rd == 10));
        st = do_start || (extra_start && (m_state == M_ACT) && (m_rd == 5));
        if (mode == 0) begin
            v = hist[3];
        end else begin
            v = (pending > 0) && ($urandom_range(3, 0) != 0);
            if (v) pending--;
        end
        rst = do_rst; start = st; ack = a; vld = v;
        #1;
        e_ce = (m_state == M_ACT);
        e_en = e_ce && (m_rd < m_pix);
        e_wr = e_ce && v && (m_res < m_pix);
        chk("busy", 32'(o_busy), 32'(m_state != M_IDLE));
        chk("done", 32'(o_done), 32'(m_state == M_FIN));
        chk("param_req", 32'(o_req), 32'(m_state == M_LOAD));
        if (m_state == M_LOAD) chk("param_grp", 32'(o_grp), m_pass);
        chk("fm_rd_en", 32'(o_rd_en), 32'(e_en));
        if (e_en) chk("fm_rd_addr", 32'(o_rd_addr), m_rd);
        chk("dp_ce", 32'(o_ce), 32'(e_ce));
        chk("dp_input_vld", 32'(o_in_vld), 32'(m_prev_rd));
        chk("out_wr_en", 32'(o_wr_en), 32'(e_wr));
        if (e_wr) exp_q.push_back(m_pass * m_pix + m_res);
        if (o_wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) chk("wr_unexpected", 32'(o_wr_addr), 32'hFFFF_FFFF);
            else chk("out_wr_addr", 32'(o_wr_addr), exp_q.pop_front());
        end
        if (o_rd_en) n_rd++;
        if (o_done) n_done++;
        if (o_req) n_req++;
        hist = {hist[6:0], o_rd_en};
        if (do_rst) begin
            m_state = M_IDLE; m_pass = 0; m_rd = 0; m_res = 0; m_prev_rd = 1'b0;
        end else begin
            m_prev_rd = e_en;
            case (m_state)
                M_IDLE: if (st) begin m_state = M_LOAD; m_pass = 0; m_loadcyc = 0; end
                M_LOAD: begin
                    if (a) begin
                        m_state = M_ACT; m_rd = 0; m_res = 0;
                        if (mode == 1) pending = 40;
                    end else begin
                        m_loadcyc++;
                    end
                end
                M_ACT: begin
                    drain = (m_rd == m_pix);
                    if (e_en) m_rd++;
                    if (e_wr) m_res++;
                    if (drain && (m_res == m_pix)) m_state = M_GAP;
                end
                M_GAP: begin
                    if (m_pass == m_passes - 1) m_state = M_FIN;
                    else begin m_pass++; m_state = M_LOAD; m_loadcyc = 0; end
                end
                M_FIN: m_state = M_IDLE;
                default: m_state = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_layer(input int budget);
        int n = 0;
        cycle(1'b0, 1'b1);
        while ((m_state != M_IDLE) && (n < budget)) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        chk("layer_timeout", 32'(n < budget), 32'd1);
        repeat (3) cycle(1'b0, 1'b0);
    endtask

    task automatic check_totals(input string tag, input int wr, input int rd, input int dn);
        chk({tag, "_writes"}, n_wr, wr);
        chk({tag, "_reads"}, n_rd, rd);
        chk({tag, "_dones"}, n_done, dn);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({o_busy, o_done, o_req, o_rd_en, o_ce, o_in_vld, o_wr_en}), 32'd0);
        chk({tag, "_grp"}, 32'(o_grp), 32'd0);
        chk({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
        chk({tag, "_wr_addr"}, 32'(o_wr_addr), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; ack = 1'b0; vld = 1'b0; sel = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        cycle(1'b1, 1'b0);

        // Baseline: ack after 3 cycles, datapath latency 4.
        clear_counts(); mode = 0; ack_delay = 3;
        run_layer(400);
        check_totals("base", 72, 72, 1);

        // Slow loader: request held until a late ack.
        clear_counts(); ack_delay = 20;
        run_layer(400);
        check_totals("slow_ack", 72, 72, 1);
        chk("slow_ack_req_cycles", n_req, 42);

        // Bursty datapath emitting 40 results per pass.
        clear_counts(); ack_delay = 3; mode = 1;
        run_layer(600);
        check_totals("extra_vld", 72, 72, 1);

        // Reset in the middle of pass 1 streaming, then a clean restart.
        clear_counts(); mode = 0;
        cycle(1'b0, 1'b1);
        n = 0;
        while (!((m_pass == 1) && (m_state == M_ACT) && (m_rd == 10)) && (n < 400)) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        chk("rst_reach_timeout", 32'(n < 400), 32'd1);
        cycle(1'b1, 1'b0);
        check_all_zero("midrst");
        repeat (6) cycle(1'b0, 1'b0);
        chk("midrst_no_done", n_done, 0);
        clear_counts();
        run_layer(400);
        check_totals("restart", 72, 72, 1);

        // Spurious start and ack while the layer is running.
        clear_counts(); extra_start = 1'b1; extra_ack = 1'b1;
        run_layer(400);
        extra_start = 1'b0; extra_ack = 1'b0;
        check_totals("spurious", 72, 72, 1);

        // Single pass with a single pixel on the second instance.
        sel = 1'b1; m_pix = 1; m_passes = 1;
        cycle(1'b1, 1'b0);
        clear_counts();
        run_layer(100);
        check_totals("tiny", 1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
